// File: rtl/win3x3_gen.sv
// win3x3_gen: 3x3 neighbourhood window generator for a raster pixel stream.
// Latency: out_valid 1 clk after the triggering in_valid (2 clk with WIN3X3_BOX_SUM_EN).
// Backpressure: none; accepts one pixel per in_valid strobe at any duty cycle.
//
// Optional feature macro: WIN3X3_BOX_SUM_EN (adds a register stage and the 9-pixel sum on out_sum).
// Ports:
//   clk, reset     pixel clock, synchronous active-high reset
//   in_pix/x/y     pixel value and raster coordinates, qualified by in_valid
//   out_win        72-bit window, row-major, [7:0] = top-left, [71:64] = bottom-right
//   out_x/out_y    window centre coordinates
//   out_valid      one strobe per emitted window
//   out_sum        sum of the 9 window pixels (0 when the sum feature is not built)
module win3x3_gen #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_pix,
    input  logic [9:0]  in_x,
    input  logic [9:0]  in_y,
    input  logic        in_valid,
    output logic [71:0] out_win,
    output logic [9:0]  out_x,
    output logic [9:0]  out_y,
    output logic        out_valid,
    output logic [11:0] out_sum
);
    localparam int          AW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [9:0]  WIDTH_C  = 10'(WIDTH);
    localparam logic [9:0]  HEIGHT_C = 10'(HEIGHT);

    // Line buffers: lb0 holds row y-1, lb1 holds row y-2. Not reset.
    logic [7:0] lb0_mem [WIDTH];
    logic [7:0] lb1_mem [WIDTH];

    // Column registers: [7:0]=top (y-2), [15:8]=mid (y-1), [23:16]=bottom (y).
    // col0 is column x-1, col1 is column x-2 relative to the incoming pixel.
    logic [23:0] col0_q, col0_d;
    logic [23:0] col1_q, col1_d;
    logic        sync_q, sync_d;
    logic [71:0] win_q, win_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        vld_q, vld_d;

    logic [AW-1:0] addr;
    logic          in_range;
    logic          at_origin;
    logic          accept;
    logic          emit;
    logic [23:0]   col_new;
    logic [71:0]   win_c;

    always_comb begin
        addr      = in_x[AW-1:0];
        in_range  = (in_x < WIDTH_C) && (in_y < HEIGHT_C);
        at_origin = (in_x == 10'd0) && (in_y == 10'd0);
        accept    = !reset && in_valid && in_range && (sync_q || at_origin);
        emit      = accept && (in_x >= 10'd2) && (in_y >= 10'd2);
        // Reads see the old contents; the write lands at the clock edge.
        col_new   = {in_pix, lb0_mem[addr], lb1_mem[addr]};
        win_c     = {col_new[23:16], col0_q[23:16], col1_q[23:16],
                     col_new[15:8],  col0_q[15:8],  col1_q[15:8],
                     col_new[7:0],   col0_q[7:0],   col1_q[7:0]};

        sync_d = sync_q || accept;
        col0_d = accept ? col_new : col0_q;
        col1_d = accept ? col0_q  : col1_q;
        vld_d  = emit;
        win_d  = emit ? win_c          : win_q;
        x_d    = emit ? in_x - 10'd1   : x_q;
        y_d    = emit ? in_y - 10'd1   : y_q;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_mem[addr] <= lb0_mem[addr];
            lb0_mem[addr] <= in_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 1'b0;
            col0_q <= '0;
            col1_q <= '0;
            vld_q  <= 1'b0;
            win_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            sync_q <= sync_d;
            col0_q <= col0_d;
            col1_q <= col1_d;
            vld_q  <= vld_d;
            win_q  <= win_d;
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end

`ifdef WIN3X3_BOX_SUM_EN
    // Second stage: sum the captured window, keep all outputs aligned with it.
    logic [71:0] owin_q, owin_d;
    logic [9:0]  ox_q, ox_d;
    logic [9:0]  oy_q, oy_d;
    logic        ovld_q, ovld_d;
    logic [11:0] osum_q, osum_d;
    logic [11:0] sum_c;

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < 9; i++) begin
            sum_c = sum_c + 12'(win_q[i*8 +: 8]);
        end
        ovld_d = vld_q;
        owin_d = vld_q ? win_q : owin_q;
        ox_d   = vld_q ? x_q   : ox_q;
        oy_d   = vld_q ? y_q   : oy_q;
        osum_d = vld_q ? sum_c : osum_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovld_q <= 1'b0;
            owin_q <= '0;
            ox_q   <= '0;
            oy_q   <= '0;
            osum_q <= '0;
        end else begin
            ovld_q <= ovld_d;
            owin_q <= owin_d;
            ox_q   <= ox_d;
            oy_q   <= oy_d;
            osum_q <= osum_d;
        end
    end

    assign out_valid = ovld_q;
    assign out_win   = owin_q;
    assign out_x     = ox_q;
    assign out_y     = oy_q;
    assign out_sum   = osum_q;
`else
    assign out_valid = vld_q;
    assign out_win   = win_q;
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_sum   = '0;
`endif

endmodule
